// File: rtl/dac_timekeeper.sv
// Time-of-day core: divides clk to a 1 Hz tick and keeps HH:MM:SS in packed BCD.
// Latency: time fields, sec_pulse and day_wrap update one clk after the tick edge.
// Backpressure: none; set pulses act every high cycle. Optional 12h view: DAC_12H_MODE_EN.
module dac_timekeeper #(
   parameter int TICKS_PER_SEC = 10000000,
   parameter int PRESCALE_W    = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       sec_clr,
   input  logic       min_inc,
   input  logic       hr_inc,
   output logic [7:0] hours_bcd,
   output logic [7:0] minutes_bcd,
   output logic [7:0] seconds_bcd,
   output logic       sec_pulse,
   output logic       day_wrap,
   output logic       blink,
   output logic       pm
);

   localparam logic [PRESCALE_W-1:0] PS_LAST = PRESCALE_W'(TICKS_PER_SEC - 1);
   localparam logic [PRESCALE_W-1:0] PS_HALF = PRESCALE_W'(TICKS_PER_SEC / 2);
   localparam logic [PRESCALE_W-1:0] PS_ONE  = PRESCALE_W'(1);

   logic [PRESCALE_W-1:0] prescaler;
   logic [7:0]            hr_q;
   logic [7:0]            min_q;
   logic [7:0]            sec_q;
   logic                  sec_pulse_q;
   logic                  day_wrap_q;

   logic                  tick;
   logic                  adv_sec;
   logic                  sec_carry;
   logic                  min_carry;
   logic                  hr_wrap;

   // Increment a two-digit BCD field, returning to 00 after its top value.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
      if (v == top)
         return 8'h00;
      else if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // A tick that coincides with sec_clr is swallowed. A manual increment into a
   // field that is also receiving a carry advances it once and kills its onward carry.
   assign tick      = run && (prescaler == PS_LAST);
   assign adv_sec   = tick && !sec_clr;
   assign sec_carry = adv_sec && (sec_q == 8'h59);
   assign min_carry = sec_carry && !min_inc && (min_q == 8'h59);
   assign hr_wrap   = min_carry && !hr_inc && (hr_q == 8'h23);

   // Prescaler: clear on sec_clr, count and wrap while running, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         prescaler <= '0;
      else if (sec_clr)
         prescaler <= '0;
      else if (run) begin
         if (tick)
            prescaler <= '0;
         else
            prescaler <= prescaler + PS_ONE;
      end
   end

   // Time fields plus the registered pulses that line up with their new values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sec_q       <= 8'h00;
         min_q       <= 8'h00;
         hr_q        <= 8'h00;
         sec_pulse_q <= 1'b0;
         day_wrap_q  <= 1'b0;
      end else begin
         if (sec_clr)
            sec_q <= 8'h00;
         else if (adv_sec)
            sec_q <= bcd_inc(sec_q, 8'h59);
         if (min_inc || sec_carry)
            min_q <= bcd_inc(min_q, 8'h59);
         if (hr_inc || min_carry)
            hr_q <= bcd_inc(hr_q, 8'h23);
         sec_pulse_q <= adv_sec;
         day_wrap_q  <= hr_wrap;
      end
   end

   assign seconds_bcd = sec_q;
   assign minutes_bcd = min_q;
   assign sec_pulse   = sec_pulse_q;
   assign day_wrap    = day_wrap_q;
   assign blink       = (prescaler < PS_HALF);

`ifdef DAC_12H_MODE_EN
   logic [4:0] hr_bin;
   logic [4:0] hr12_bin;

   // 12-hour presentation derived combinationally from the 24-hour register.
   always_comb begin
      hr_bin   = (5'd10 * {1'b0, hr_q[7:4]}) + {1'b0, hr_q[3:0]};
      hr12_bin = hr_bin;
      if (hr_bin == 5'd0)
         hr12_bin = 5'd12;
      else if (hr_bin > 5'd12)
         hr12_bin = hr_bin - 5'd12;
      if (hr12_bin >= 5'd10)
         hours_bcd = {4'd1, 4'(hr12_bin - 5'd10)};
      else
         hours_bcd = {4'd0, hr12_bin[3:0]};
      pm = (hr_bin >= 5'd12);
   end
`else
   assign hours_bcd = hr_q;
   assign pm        = 1'b0;
`endif

endmodule

// File: tb/tb_dac_timekeeper.sv
// Directed bench for dac_timekeeper with TICKS_PER_SEC=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants; 12h expectations follow DAC_12H_MODE_EN.
module tb_dac_timekeeper;

   logic       clk;
   logic       rst_n;
   logic       run;
   logic       sec_clr;
   logic       min_inc;
   logic       hr_inc;
   logic [7:0] hours_bcd;
   logic [7:0] minutes_bcd;
   logic [7:0] seconds_bcd;
   logic       sec_pulse;
   logic       day_wrap;
   logic       blink;
   logic       pm;

   int total = 0;
   int bad   = 0;

   dac_timekeeper #(
      .TICKS_PER_SEC(4),
      .PRESCALE_W   (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .sec_clr    (sec_clr),
      .min_inc    (min_inc),
      .hr_inc     (hr_inc),
      .hours_bcd  (hours_bcd),
      .minutes_bcd(minutes_bcd),
      .seconds_bcd(seconds_bcd),
      .sec_pulse  (sec_pulse),
      .day_wrap   (day_wrap),
      .blink      (blink),
      .pm         (pm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                             input logic [7:0] s);
      check({tag, ".hours"}, hours_bcd, h);
      check({tag, ".minutes"}, minutes_bcd, m);
      check({tag, ".seconds"}, seconds_bcd, s);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      run     = 1'b0;
      sec_clr = 1'b0;
      min_inc = 1'b0;
      hr_inc  = 1'b0;
      cyc(1);
      rst_n = 1'b1;
   endtask

   logic [7:0] exp_h;
   logic       exp_pm;

   initial begin
      rst_n   = 1'b0;
      run     = 1'b0;
      sec_clr = 1'b0;
      min_inc = 1'b0;
      hr_inc  = 1'b0;
      #3;
      // Reset state
      check_time("rst", 8'h00, 8'h00, 8'h00);
      check("rst.sec_pulse", {7'd0, sec_pulse}, 8'd0);
      check("rst.day_wrap", {7'd0, day_wrap}, 8'd0);
      check("rst.pm", {7'd0, pm}, 8'd0);
      check("rst.blink", {7'd0, blink}, 8'd1);
      cyc(1);
      rst_n = 1'b1;

      // 1. First second: blink 2 high / 2 low, one-cycle sec_pulse on the 4th edge
      run = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         cyc(1);
         check($sformatf("p1.blink%0d", i), {7'd0, blink}, ((i % 4) < 2) ? 8'd1 : 8'd0);
         check($sformatf("p1.pulse%0d", i), {7'd0, sec_pulse}, (i == 4) ? 8'd1 : 8'd0);
         check($sformatf("p1.sec%0d", i), seconds_bcd, (i >= 4) ? 8'h01 : 8'h00);
      end

      // 2. Set 23:59, count 59 s, then the day wrap
      do_reset();
      hr_inc = 1'b1;
      cyc(23);
      hr_inc = 1'b0;
      check("p2.hr23", hours_bcd, 8'h23);
      min_inc = 1'b1;
      cyc(59);
      min_inc = 1'b0;
      check("p2.min59", minutes_bcd, 8'h59);
      run = 1'b1;
      cyc(236);
      check_time("p2.235959", 8'h23, 8'h59, 8'h59);
      cyc(3);
      check("p2.no_wrap_yet", {7'd0, day_wrap}, 8'd0);
      cyc(1);
      check_time("p2.wrap", 8'h00, 8'h00, 8'h00);
      check("p2.day_wrap", {7'd0, day_wrap}, 8'd1);
      check("p2.sec_pulse", {7'd0, sec_pulse}, 8'd1);
      cyc(1);
      check("p2.day_wrap_off", {7'd0, day_wrap}, 8'd0);

      // 3. Manual increments never carry and never flag day_wrap
      do_reset();
      min_inc = 1'b1;
      cyc(59);
      min_inc = 1'b0;
      run = 1'b1;
      cyc(120);
      run = 1'b0;
      check_time("p3.005930", 8'h00, 8'h59, 8'h30);
      min_inc = 1'b1;
      cyc(1);
      min_inc = 1'b0;
      check_time("p3.min_wrap", 8'h00, 8'h00, 8'h30);
      hr_inc = 1'b1;
      cyc(23);
      check("p3.hr23", hours_bcd, 8'h23);
      cyc(1);
      hr_inc = 1'b0;
      check_time("p3.hr_wrap", 8'h00, 8'h00, 8'h30);
      check("p3.no_day_wrap", {7'd0, day_wrap}, 8'd0);

      // 4. Manual increment coinciding with an automatic carry
      do_reset();
      min_inc = 1'b1;
      cyc(5);
      min_inc = 1'b0;
      run = 1'b1;
      cyc(236);
      cyc(3);
      check_time("p4.000559", 8'h00, 8'h05, 8'h59);
      min_inc = 1'b1;
      cyc(1);
      min_inc = 1'b0;
      check_time("p4.min_coinc", 8'h00, 8'h06, 8'h00);
      check("p4.pulse", {7'd0, sec_pulse}, 8'd1);
      do_reset();
      hr_inc = 1'b1;
      cyc(5);
      hr_inc = 1'b0;
      min_inc = 1'b1;
      cyc(59);
      min_inc = 1'b0;
      run = 1'b1;
      cyc(239);
      hr_inc = 1'b1;
      cyc(1);
      hr_inc = 1'b0;
      check_time("p4.hr_coinc", 8'h06, 8'h00, 8'h00);

      // 5. sec_clr, run freeze, asynchronous reset mid-count
      do_reset();
      run = 1'b1;
      cyc(148);
      cyc(2);
      check("p5.sec37", seconds_bcd, 8'h37);
      sec_clr = 1'b1;
      cyc(1);
      sec_clr = 1'b0;
      check("p5.clr_sec", seconds_bcd, 8'h00);
      check("p5.clr_pulse", {7'd0, sec_pulse}, 8'd0);
      cyc(3);
      check("p5.pre_tick_sec", seconds_bcd, 8'h00);
      check("p5.pre_tick_pulse", {7'd0, sec_pulse}, 8'd0);
      cyc(1);
      check("p5.tick4_sec", seconds_bcd, 8'h01);
      check("p5.tick4_pulse", {7'd0, sec_pulse}, 8'd1);
      cyc(3);
      sec_clr = 1'b1;
      min_inc = 1'b1;
      cyc(1);
      sec_clr = 1'b0;
      min_inc = 1'b0;
      check_time("p5.clr_on_tick", 8'h00, 8'h01, 8'h00);
      check("p5.suppressed_pulse", {7'd0, sec_pulse}, 8'd0);
      cyc(2);
      run = 1'b0;
      cyc(20);
      check_time("p5.frozen", 8'h00, 8'h01, 8'h00);
      check("p5.frozen_blink", {7'd0, blink}, 8'd0);
      run = 1'b1;
      cyc(1);
      check("p5.resume_sec", seconds_bcd, 8'h00);
      cyc(1);
      check("p5.resume_tick", seconds_bcd, 8'h01);
      cyc(2);
      #2;
      rst_n = 1'b0;
      #1;
      check_time("p5.async_rst", 8'h00, 8'h00, 8'h00);
      check("p5.async_blink", {7'd0, blink}, 8'd1);
      cyc(1);
      rst_n = 1'b1;
      cyc(3);
      check("p5.partial_discard", seconds_bcd, 8'h00);
      cyc(1);
      check("p5.fresh_second", seconds_bcd, 8'h01);

      // 6. Hour presentation
      do_reset();
`ifdef DAC_12H_MODE_EN
      exp_h = 8'h12;
      exp_pm = 1'b0;
`else
      exp_h = 8'h00;
      exp_pm = 1'b0;
`endif
      check("p6.h00", hours_bcd, exp_h);
      check("p6.pm00", {7'd0, pm}, {7'd0, exp_pm});
      hr_inc = 1'b1;
      cyc(12);
      hr_inc = 1'b0;
`ifdef DAC_12H_MODE_EN
      exp_pm = 1'b1;
`endif
      check("p6.h12", hours_bcd, 8'h12);
      check("p6.pm12", {7'd0, pm}, {7'd0, exp_pm});
      hr_inc = 1'b1;
      cyc(1);
      hr_inc = 1'b0;
`ifdef DAC_12H_MODE_EN
      exp_h = 8'h01;
`else
      exp_h = 8'h13;
`endif
      check("p6.h13", hours_bcd, exp_h);
      check("p6.pm13", {7'd0, pm}, {7'd0, exp_pm});
      hr_inc = 1'b1;
      cyc(10);
      hr_inc = 1'b0;
`ifdef DAC_12H_MODE_EN
      exp_h = 8'h11;
`else
      exp_h = 8'h23;
`endif
      check("p6.h23", hours_bcd, exp_h);
      check("p6.pm23", {7'd0, pm}, {7'd0, exp_pm});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
